// File: rtl/wrt_queue_axi.sv
// FIFO write-back queue draining cache evictions / uncached stores onto an AXI write port.
// Optional store-to-load forwarding when WRT_QUEUE_FWD_EN is defined.
module wrt_queue_axi #(
  parameter int LINE_W = 512,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [ADDR_W-1:0]   push_addr,
  input  logic                push_uncache,
  input  logic [LINE_W-1:0]   push_line,
  input  logic [DATA_W/8-1:0] push_strb,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                empty,
  output logic                wrt_finish,
  output logic                err
`ifdef WRT_QUEUE_FWD_EN
  ,
  input  logic [ADDR_W-1:0]   fwd_addr,
  output logic                fwd_hit,
  output logic [LINE_W-1:0]   fwd_line
`endif
);
  localparam int BEATS = LINE_W / DATA_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = DATA_W / 8;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  state_t state;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic              unc_q  [DEPTH];
  logic [LINE_W-1:0] line_q [DEPTH];
  logic [SW-1:0]     strb_q [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [BW-1:0] beat;
  logic          push_fire, pop;
  logic [ADDR_W-1:0] h_addr;
  logic              h_unc;
  logic [LINE_W-1:0] h_line;
  logic [SW-1:0]     h_strb;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ready = (count < CW'(DEPTH));
  assign push_fire  = push_valid && push_ready;
  assign pop        = bvalid && bready;
  assign empty      = (count == '0) && (state == IDLE);

  assign h_addr = addr_q[head];
  assign h_unc  = unc_q[head];
  assign h_line = line_q[head];
  assign h_strb = strb_q[head];

  // AW/W payload comes straight from the head slot, which is never rewritten while in flight
  assign awaddr  = h_unc ? h_addr : {h_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign awlen   = h_unc ? 8'd0 : 8'(BEATS - 1);
  assign awsize  = 3'($clog2(SW));
  assign awburst = 2'b01;
  assign wdata   = h_line[int'(beat)*DATA_W +: DATA_W];
  assign wstrb   = h_unc ? h_strb : {SW{1'b1}};
  assign wlast   = wvalid && (h_unc || (beat == BW'(BEATS - 1)));

  always_ff @(posedge clk) begin
    if (push_fire) begin
      addr_q[tail] <= push_addr;
      unc_q[tail]  <= push_uncache;
      line_q[tail] <= push_line;
      strb_q[tail] <= push_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      wrt_finish <= 1'b0;
      err        <= 1'b0;
      beat       <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      wrt_finish <= 1'b0;
      if (push_fire) tail <= nxt(tail);
      if (pop) head <= nxt(head);
      count <= count + CW'(push_fire) - CW'(pop);
      case (state)
        IDLE: if (count != '0) begin
          state   <= AW;
          awvalid <= 1'b1;
        end
        AW: if (awready) begin
          state   <= W;
          awvalid <= 1'b0;
          wvalid  <= 1'b1;
          beat    <= '0;
        end
        W: if (wready) begin
          if (wlast) begin
            state  <= B;
            wvalid <= 1'b0;
            bready <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        B: if (bvalid) begin
          state      <= IDLE;
          bready     <= 1'b0;
          wrt_finish <= 1'b1;
          err        <= err | bresp[1];
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WRT_QUEUE_FWD_EN
  logic [PW-1:0] fidx;
  logic unused_bits;
  assign unused_bits = ^{bresp[0], fwd_addr[OFF-1:0]};

  // Walk oldest to youngest so the last match (youngest) wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_line = '0;
    fidx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = PW'((int'(head) + i) % DEPTH);
      if (i < int'(count) && !unc_q[fidx] &&
          addr_q[fidx][ADDR_W-1:OFF] == fwd_addr[ADDR_W-1:OFF]) begin
        fwd_hit  = 1'b1;
        fwd_line = line_q[fidx];
      end
    end
  end
`else
  logic unused_bits;
  assign unused_bits = bresp[0];
`endif
endmodule

// File: tb/tb_wrt_queue_axi.sv
// Bench for wrt_queue_axi: directed vector table, hand sequences, random stalls vs a queue model.
module tb_wrt_queue_axi;
  localparam int LINE_W = 512, DATA_W = 32, ADDR_W = 32, DEPTH = 2;
  localparam int BEATS = LINE_W / DATA_W, SW = DATA_W / 8;

  logic clk = 0, rst = 1;
  logic push_valid = 0, push_uncache = 0;
  logic push_ready;
  logic [ADDR_W-1:0] push_addr = '0;
  logic [LINE_W-1:0] push_line = '0;
  logic [SW-1:0] push_strb = '0;
  logic awvalid, awready = 0, wvalid, wready = 0, wlast, bvalid = 0, bready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp = 2'b00;
  logic [DATA_W-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic empty, wrt_finish, err;
`ifdef WRT_QUEUE_FWD_EN
  logic [ADDR_W-1:0] fwd_addr = '0;
  logic fwd_hit;
  logic [LINE_W-1:0] fwd_line;
`endif

  wrt_queue_axi #(.LINE_W(LINE_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_uncache(push_uncache), .push_line(push_line),
    .push_strb(push_strb), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid), .bready(bready),
    .bresp(bresp), .empty(empty), .wrt_finish(wrt_finish), .err(err)
`ifdef WRT_QUEUE_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_line(fwd_line)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              unc;
    logic [LINE_W-1:0] line;
    logic [SW-1:0]     strb;
  } ent_t;

  int errors = 0, checks = 0;
  ent_t mq[$];
  logic [1:0] bresp_q[$];
  int mode = 0;
  int mbeat = 0, retired = 0, since_b = 100, qn_after_b = 0;
  bit aw_done = 0, fin_exp = 0, err_m = 0, pend_b = 0;
  bit pa_stall = 0, pw_stall = 0;
  logic [ADDR_W-1:0] pa_addr;
  logic [DATA_W-1:0] pw_data;
  logic [SW-1:0] pw_strb;
  logic pw_last;
  logic [ADDR_W-1:0] cap_awaddr;
  logic [7:0] cap_awlen;
  logic [SW-1:0] cap_wstrb;
  int cap_beats;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rline();
    logic [LINE_W-1:0] r;
    for (int j = 0; j < BEATS; j++) r[j*DATA_W +: DATA_W] = $urandom();
    return r;
  endfunction

  // Ready/response driver: inputs change 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    case (mode)
      1:       begin awready = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1)); end
      2:       begin awready = 0; wready = 1; end
      default: begin awready = 1; wready = 1; end
    endcase
    bvalid = pend_b && (mode != 1 || $urandom_range(0, 2) != 0);
    bresp  = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
  end

  // Reference model: FIFO of pushed entries; each AXI handshake is judged against the oldest one
  always @(negedge clk) begin
    bit b_now;
    b_now = 0;
    if (rst) begin
      mq.delete(); mbeat = 0; aw_done = 0; fin_exp = 0; err_m = 0; pend_b = 0;
      since_b = 100; pa_stall = 0; pw_stall = 0;
    end else begin
      chk("push_ready", push_ready, mq.size() < DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("wrt_finish", wrt_finish, fin_exp);
      chk("err", err, err_m);
      fin_exp = 0;
      if (pa_stall) begin chk("aw_hold_valid", awvalid, 1); chk("aw_hold_addr", awaddr, pa_addr); end
      if (pw_stall) begin
        chk("w_hold_valid", wvalid, 1); chk("w_hold_data", wdata, pw_data);
        chk("w_hold_strb", wstrb, pw_strb); chk("w_hold_last", wlast, pw_last);
      end
      if (since_b < 100) since_b++;
      if (since_b == 1) chk("b2b_idle_gap", awvalid, 0);
      if (since_b == 2 && qn_after_b > 0) chk("b2b_aw_t2", awvalid, 1);
      if (wvalid) chk("w_after_aw", aw_done, 1);
      if (awvalid && awready) begin
        if (mq.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          chk("awaddr", awaddr, mq[0].unc ? mq[0].addr : (mq[0].addr & ~32'h3F));
          chk("awlen", awlen, mq[0].unc ? 0 : BEATS - 1);
          chk("awsize", awsize, 2);
          chk("awburst", awburst, 1);
          cap_awaddr = awaddr; cap_awlen = awlen;
        end
        aw_done = 1;
      end
      if (wvalid && wready && mq.size() > 0) begin
        int nb;
        nb = mq[0].unc ? 1 : BEATS;
        chk("wdata", wdata, mq[0].line[mbeat*DATA_W +: DATA_W]);
        chk("wstrb", wstrb, mq[0].unc ? mq[0].strb : {SW{1'b1}});
        chk("wlast", wlast, mbeat == nb - 1);
        cap_wstrb = wstrb;
        mbeat++;
        if (mbeat == nb) begin pend_b = 1; cap_beats = mbeat; end
      end
      if (bvalid && bready) begin
        chk("b_after_wlast", pend_b, 1);
        err_m = err_m | bresp[1];
        if (mq.size() > 0) void'(mq.pop_front());
        if (bresp_q.size() > 0) void'(bresp_q.pop_front());
        aw_done = 0; mbeat = 0; pend_b = 0; fin_exp = 1; since_b = 0; retired++;
        b_now = 1;
      end
      if (push_valid && push_ready)
        mq.push_back('{addr: push_addr, unc: push_uncache, line: push_line, strb: push_strb});
      if (b_now) qn_after_b = mq.size();
      pa_stall = awvalid && !awready; pa_addr = awaddr;
      pw_stall = wvalid && !wready; pw_data = wdata; pw_strb = wstrb; pw_last = wlast;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic push(input logic [ADDR_W-1:0] a, input logic u,
                      input logic [LINE_W-1:0] l, input logic [SW-1:0] s);
    bit ok;
    ok = 0;
    push_valid = 1; push_addr = a; push_uncache = u; push_line = l; push_strb = s;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (push_ready) begin ok = 1; break; end
    end
    chk("push_timeout", ok, 1);
    @(posedge clk); #1;
    push_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (empty && mq.size() == 0 && !pend_b) begin ok = 1; break; end
    end
    chk("drain_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              unc;
    logic [SW-1:0]     strb;
    bit                count_line;
    logic [ADDR_W-1:0] e_awaddr;
    logic [7:0]        e_awlen;
    logic [SW-1:0]     e_wstrb;
    int                e_beats;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[4];
    logic [LINE_W-1:0] ln, l2;
    int r0;
    bit ok;
    tv[0] = '{32'h1000_0044, 1'b0, 4'h0,    1'b1, 32'h1000_0040, 8'd15, 4'hF,    16};
    tv[1] = '{32'hBFAF_8002, 1'b1, 4'b1100, 1'b0, 32'hBFAF_8002, 8'd0,  4'b1100, 1};
    tv[2] = '{32'h0000_003F, 1'b0, 4'hF,    1'b0, 32'h0000_0000, 8'd15, 4'hF,    16};
    tv[3] = '{32'hFFFF_FFFC, 1'b1, 4'b0001, 1'b0, 32'hFFFF_FFFC, 8'd0,  4'b0001, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0); chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0); chk("rst_finish", wrt_finish, 0); chk("rst_err", err, 0);
    chk("rst_empty", empty, 1); chk("rst_push_ready", push_ready, 1);
    @(posedge clk); #1 rst = 0;

    // Directed vectors, AXI always ready
    mode = 0;
    for (int i = 0; i < 4; i++) begin
      if (tv[i].count_line) for (int j = 0; j < BEATS; j++) ln[j*DATA_W +: DATA_W] = j;
      else ln = rline();
      r0 = retired;
      push(tv[i].addr, tv[i].unc, ln, tv[i].strb);
      wait_idle();
      chk("vec_awaddr", cap_awaddr, tv[i].e_awaddr);
      chk("vec_awlen", cap_awlen, tv[i].e_awlen);
      chk("vec_wstrb", cap_wstrb, tv[i].e_wstrb);
      chk("vec_beats", cap_beats, tv[i].e_beats);
      chk("vec_retired", retired, r0 + 1);
    end

    // Fill to DEPTH with AW blocked; third push must wait for the first retire
    mode = 2;
    r0 = retired;
    push(32'h2000_0000, 0, rline(), 4'hF);
    push(32'h2000_0100, 1, rline(), 4'b0110);
    push_valid = 1; push_addr = 32'h2000_0200; push_uncache = 0; push_line = rline();
    repeat (4) begin @(negedge clk); chk("full_block", push_ready, 0); end
    @(posedge clk); #1;
    mode = 0;
    push(push_addr, push_uncache, push_line, push_strb);
    wait_idle();
    chk("full_retired", retired, r0 + 3);

    // Random payloads with random AW/W/B stalls
    mode = 1;
    r0 = retired;
    for (int i = 0; i < 12; i++) begin
      push($urandom(), 1'($urandom_range(0, 1)), rline(), 4'($urandom()));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle();
    chk("rand_retired", retired, r0 + 12);

    // Error response is sticky
    mode = 0;
    @(negedge clk); chk("err_pre", err, 0);
    @(posedge clk); #1;
    bresp_q.push_back(2'b10); bresp_q.push_back(2'b00);
    r0 = retired;
    push(32'h3000_0000, 0, rline(), 4'hF);
    push(32'h3000_0040, 1, rline(), 4'hF);
    wait_idle();
    @(negedge clk); chk("err_sticky", err, 1);
    @(posedge clk); #1;
    push(32'h3000_0080, 0, rline(), 4'hF);
    wait_idle();
    @(negedge clk); chk("err_sticky2", err, 1); chk("err_retired", retired, r0 + 3);
    @(posedge clk); #1;

    // Reset while W beat 7 is on the bus
    push(32'h4000_0000, 0, rline(), 4'hF);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (mbeat == 7) begin ok = 1; break; end
    end
    chk("beat7_reached", ok, 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_awvalid", awvalid, 0); chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_bready", bready, 0); chk("mid_rst_wlast", wlast, 0);
    chk("mid_rst_empty", empty, 1); chk("mid_rst_push_ready", push_ready, 1);
    chk("mid_rst_err", err, 0);
    @(posedge clk); #1 rst = 0;
    push(32'h4000_0040, 1, rline(), 4'hF);
    wait_idle();

`ifdef WRT_QUEUE_FWD_EN
    mode = 2;
    ln = rline(); l2 = rline();
    push(32'h5000_0080, 1, rline(), 4'hF);
    fwd_addr = 32'h5000_0084;
    @(negedge clk); chk("fwd_uncached_miss", fwd_hit, 0);
    @(posedge clk); #1;
    push(32'h5000_0088, 0, ln, 4'hF);
    @(negedge clk); chk("fwd_hit", fwd_hit, 1);
    checks++;
    if (fwd_line !== ln) begin errors++; $display("FAIL fwd_line: got %h want %h", fwd_line, ln); end
    @(posedge clk); #1;
    mode = 0;
    wait_idle();
    @(negedge clk); chk("fwd_after_retire", fwd_hit, 0);
    @(posedge clk); #1;
    mode = 2;
    push(32'h6000_0000, 0, ln, 4'hF);
    push(32'h6000_0030, 0, l2, 4'hF);
    fwd_addr = 32'h6000_0010;
    @(negedge clk); chk("fwd_hit_multi", fwd_hit, 1);
    checks++;
    if (fwd_line !== l2) begin errors++; $display("FAIL fwd_youngest: got %h want %h", fwd_line, l2); end
    @(posedge clk); #1;
    mode = 0;
    wait_idle();
    @(negedge clk); chk("fwd_after_drain", fwd_hit, 0);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
